// File: rtl/mp3_sdi_sink.sv
// VS10xx-style SDI receiver: oversamples the serial MP3 lines, assembles bytes
// MSB-first into a FIFO, raises mp3_req while space remains and drains at a fixed rate.
module mp3_sdi_sink #(
  parameter int unsigned AW        = 5,
  parameter int unsigned REQ_FREE  = 4,
  parameter int unsigned DRAIN_DIV = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mp3_xreset,
  input  logic          mp3_clk,
  input  logic          mp3_dat,
  input  logic          mp3_sync,
  output logic          mp3_req,
  input  logic          drain_en,
  output logic          byte_stb,
  output logic [7:0]    byte_data,
  output logic [AW:0]   fill,
  output logic          overflow,
  output logic          sync_err
);

  localparam int unsigned DEPTH = 2**AW;
  localparam logic [AW+1:0] DEPTH_W  = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] REQ_W    = (AW+2)'(REQ_FREE);
  localparam logic [AW:0]   FULL_W   = (AW+1)'(DEPTH);
  localparam logic [9:0]    DIV_LAST = 10'(DRAIN_DIV - 1);

  logic [1:0]    clk_sy, dat_sy, sync_sy, xr_sy;
  logic          clk_d;
  logic          bit_evt, dat_s, sync_s, xr_s;
  logic [7:0]    shreg;
  logic [2:0]    bc;
  logic          wr_pend;
  logic [7:0]    wr_byte;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [9:0]    dcnt;
  logic          run, pop, full, push, req_ok;
  logic [AW+1:0] free_w;

  assign dat_s   = dat_sy[1];
  assign sync_s  = sync_sy[1];
  assign xr_s    = xr_sy[1];
  assign bit_evt = clk_sy[1] & ~clk_d;

  // Pop is resolved first so a write into a full FIFO still lands when a byte leaves.
  always_comb begin
    run    = drain_en & (fill != '0);
    pop    = run & (dcnt == DIV_LAST);
    full   = (fill == FULL_W);
    push   = wr_pend & (~full | pop);
    free_w = DEPTH_W - {1'b0, fill};
    req_ok = (free_w >= REQ_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sy    <= '0;
      dat_sy    <= '0;
      sync_sy   <= '0;
      xr_sy     <= '0;
      clk_d     <= 1'b0;
      mp3_req   <= 1'b0;
      byte_stb  <= 1'b0;
      byte_data <= '0;
      fill      <= '0;
      overflow  <= 1'b0;
      sync_err  <= 1'b0;
      shreg     <= '0;
      bc        <= '0;
      wr_pend   <= 1'b0;
      wr_byte   <= '0;
      wptr      <= '0;
      rptr      <= '0;
      dcnt      <= '0;
    end else begin
      clk_sy   <= {clk_sy[0], mp3_clk};
      dat_sy   <= {dat_sy[0], mp3_dat};
      sync_sy  <= {sync_sy[0], mp3_sync};
      xr_sy    <= {xr_sy[0], mp3_xreset};
      clk_d    <= clk_sy[1];
      mp3_req  <= xr_s & req_ok;
      byte_stb <= 1'b0;
      if (!xr_s) begin
        fill    <= '0;
        wptr    <= '0;
        rptr    <= '0;
        bc      <= '0;
        dcnt    <= '0;
        wr_pend <= 1'b0;
      end else begin
        if (!run || pop) dcnt <= '0;
        else             dcnt <= dcnt + 1'b1;
        if (pop) begin
          byte_stb  <= 1'b1;
          byte_data <= mem[rptr];
          rptr      <= rptr + 1'b1;
        end
        if (push)         wptr     <= wptr + 1'b1;
        else if (wr_pend) overflow <= 1'b1;
        case ({push, pop})
          2'b10:   fill <= fill + 1'b1;
          2'b01:   fill <= fill - 1'b1;
          default: ;
        endcase
        wr_pend <= 1'b0;
        if (bit_evt) begin
          if (sync_s) begin
            if (bc != '0) sync_err <= 1'b1;
            shreg <= {dat_s, 7'b0};
            bc    <= 3'd1;
          end else begin
            shreg[3'd7 - bc] <= dat_s;
            bc               <= bc + 1'b1;
            if (bc == 3'd7) begin
              wr_pend <= 1'b1;
              wr_byte <= {shreg[7:1], dat_s};
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xr_s && push) mem[wptr] <= wr_byte;
  end

endmodule

// File: tb/tb_mp3_sdi_sink.sv
// Bench for mp3_sdi_sink: byte-level reference model with per-cycle output compare
// plus directed scenarios with hand-computed expectations.
module tb_mp3_sdi_sink;

  localparam int AW       = 5;
  localparam int DEPTH    = 32;
  localparam int REQ_FREE = 4;
  localparam int DIV      = 4;

  logic        clk = 0, rst_n = 0;
  logic        mp3_xreset = 1, mp3_clk = 0, mp3_dat = 0, mp3_sync = 0, drain_en = 0;
  logic        mp3_req, byte_stb, overflow, sync_err;
  logic [7:0]  byte_data;
  logic [AW:0] fill;

  int checks = 0, errors = 0;
  byte unsigned got[$];

  mp3_sdi_sink #(.AW(AW), .REQ_FREE(REQ_FREE), .DRAIN_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .mp3_xreset(mp3_xreset), .mp3_clk(mp3_clk),
    .mp3_dat(mp3_dat), .mp3_sync(mp3_sync), .mp3_req(mp3_req), .drain_en(drain_en),
    .byte_stb(byte_stb), .byte_data(byte_data), .fill(fill),
    .overflow(overflow), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: pad history stands in for the synchronizers, FIFO is a queue.
  bit hc[3], hd[3], hs[3], hx[3];
  byte unsigned mq[$];
  int nbits, acc, tick;
  bit mpend;
  byte unsigned mval, m_data;
  bit m_stb, m_req, m_ovf, m_serr;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin hc[i] = 0; hd[i] = 0; hs[i] = 0; hx[i] = 0; end
      mq.delete(); nbits = 0; acc = 0; tick = 0; mpend = 0; mval = 0;
      m_data = 0; m_stb = 0; m_req = 0; m_ovf = 0; m_serr = 0;
    end else begin
      bit ev, d, s, x, do_pop;
      int size0;
      ev = hc[1] && !hc[2]; d = hd[1]; s = hs[1]; x = hx[1];
      size0 = mq.size();
      m_req = x && ((DEPTH - size0) >= REQ_FREE);
      m_stb = 0;
      if (!x) begin
        mq.delete(); nbits = 0; tick = 0; mpend = 0;
      end else begin
        do_pop = 0;
        if (drain_en && size0 != 0) begin
          if (tick == DIV - 1) begin do_pop = 1; tick = 0; end
          else tick++;
        end else tick = 0;
        if (do_pop) begin m_data = mq.pop_front(); m_stb = 1; end
        if (mpend) begin
          if (mq.size() < DEPTH) mq.push_back(mval);
          else m_ovf = 1;
        end
        mpend = 0;
        if (ev) begin
          if (s) begin
            if (nbits != 0) m_serr = 1;
            acc = int'(d); nbits = 1;
          end else begin
            acc = (acc << 1) | int'(d); nbits++;
          end
          if (nbits == 8) begin mpend = 1; mval = 8'(acc); nbits = 0; end
        end
      end
      hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = mp3_clk;
      hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = mp3_dat;
      hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = mp3_sync;
      hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = mp3_xreset;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("byte_stb", int'(byte_stb), int'(m_stb));
      check("byte_data", int'(byte_data), int'(m_data));
      check("fill", int'(fill), mq.size());
      check("mp3_req", int'(mp3_req), int'(m_req));
      check("overflow", int'(overflow), int'(m_ovf));
      check("sync_err", int'(sync_err), int'(m_serr));
      if (byte_stb) got.push_back(byte_data);
    end
  end

  task automatic send_bit(input bit b, input bit s);
    mp3_dat = b; mp3_sync = s;
    repeat (4) @(negedge clk);
    mp3_clk = 1;
    repeat (4) @(negedge clk);
    mp3_clk = 0;
  endtask

  task automatic send_byte(input byte unsigned v, input bit with_sync);
    for (int i = 7; i >= 0; i--) send_bit(v[i], with_sync && (i == 7));
    mp3_sync = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain_n(input int n);
    int t;
    drain_en = 1;
    for (int k = 0; k < n; k++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!byte_stb && t < 200);
      if (!byte_stb) check("drain_timeout", 0, 1);
    end
    drain_en = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    got.delete();
    @(negedge clk);
    rst_n = 1;
    settle(4);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog expired at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    settle(3);
    check("rst_fill", int'(fill), 0);
    check("rst_req", int'(mp3_req), 0);
    check("rst_stb", int'(byte_stb), 0);
    check("rst_data", int'(byte_data), 0);
    check("rst_flags", int'({overflow, sync_err}), 0);
    rst_n = 1;
    settle(4);
    check("req_after_rst", int'(mp3_req), 1);

    // Sync framing with draining enabled
    drain_en = 1;
    send_byte(8'hA5, 1); send_byte(8'h3C, 1); send_byte(8'hFF, 1);
    settle(40);
    drain_en = 0;
    check("frame_count", got.size(), 3);
    if (got.size() == 3) begin
      check("frame_b0", int'(got[0]), 'hA5);
      check("frame_b1", int'(got[1]), 'h3C);
      check("frame_b2", int'(got[2]), 'hFF);
    end
    check("frame_fill", int'(fill), 0);
    check("frame_flags", int'({overflow, sync_err}), 0);

    // Request threshold
    do_reset();
    for (int i = 0; i < 28; i++) send_byte(8'(8'h10 + i), 1);
    settle(8);
    check("thr_fill28", int'(fill), 28);
    check("thr_req28", int'(mp3_req), 1);
    send_byte(8'h2C, 1);
    settle(8);
    check("thr_fill29", int'(fill), 29);
    check("thr_req29", int'(mp3_req), 0);
    drain_n(1);
    settle(2);
    check("thr_drained", int'(got[0]), 'h10);
    check("thr_fill_back", int'(fill), 28);
    check("thr_req_back", int'(mp3_req), 1);

    // Overflow
    do_reset();
    for (int i = 0; i < 33; i++) send_byte(8'(i * 7 + 3), 1);
    settle(8);
    check("ovf_fill", int'(fill), 32);
    check("ovf_flag", int'(overflow), 1);
    drain_n(32);
    settle(4);
    check("ovf_count", got.size(), 32);
    for (int i = 0; i < 32 && i < got.size(); i++) check("ovf_seq", int'(got[i]), (i * 7 + 3) & 255);
    check("ovf_empty", int'(fill), 0);

    // Mid-byte sync
    do_reset();
    send_bit(1, 1); send_bit(0, 0); send_bit(1, 0);
    send_byte(8'h81, 1);
    settle(8);
    check("msync_err", int'(sync_err), 1);
    check("msync_fill", int'(fill), 1);
    drain_n(1);
    settle(2);
    check("msync_count", got.size(), 1);
    check("msync_byte", int'(got[0]), 'h81);

    // Decoder reset mid-byte, sticky flags retained
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 1);
    settle(8);
    check("xr_fill_pre", int'(fill), 10);
    send_bit(1, 1); send_bit(1, 0);
    mp3_xreset = 0;
    settle(4);
    check("xr_fill", int'(fill), 0);
    check("xr_req", int'(mp3_req), 0);
    settle(1);
    mp3_xreset = 1;
    settle(4);
    check("xr_serr_kept", int'(sync_err), 1);
    check("xr_ovf_kept", int'(overflow), 0);
    send_byte(8'h6B, 1);
    settle(8);
    check("xr_fill_post", int'(fill), 1);
    drain_n(1);
    settle(2);
    check("xr_byte", int'(got[got.size() - 1]), 'h6B);

    // Async reset during a drain pulse
    do_reset();
    send_byte(8'hC3, 1); send_byte(8'h5A, 1);
    settle(8);
    drain_en = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!byte_stb && t < 200);
    check("arst_stb_seen", int'(byte_stb), 1);
    check("arst_stb_data", int'(byte_data), 'hC3);
    #2 rst_n = 0;
    #1;
    check("arst_stb", int'(byte_stb), 0);
    check("arst_data", int'(byte_data), 0);
    check("arst_fill", int'(fill), 0);
    check("arst_req", int'(mp3_req), 0);
    check("arst_flags", int'({overflow, sync_err}), 0);
    drain_en = 0;
    @(negedge clk);
    rst_n = 1;
    settle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
